lmsm_sequencer: RTL and testbench

- Multi-cycle controller for Load-Multiple / Store-Multiple (LM/SM) in the 16-bit RISC core.
- Takes a base address and an 8-bit register mask, then walks the mask from R7 down to R0. Each selected register gets one memory transfer at consecutive addresses.
- Sits between decode/control, the register file and the data-memory port.
- Stalls the pipeline through `busy` until the whole burst completes.

---
 rtl/lmsm_pkg.sv | 17 +
 rtl/lmsm_prienc.sv | 23 ++
 rtl/lmsm_sequencer.sv | 108 ++++++++++
 tb/tb_lmsm_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// Shared types and constants for the LM/SM burst sequencer.
// Imported by the sequencer top and its priority encoder.
package lmsm_pkg;

  localparam int NREG      = 8;
  localparam int REG_IDX_W = 3;

  localparam logic OP_LM = 1'b0;
  localparam logic OP_SM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lmsm_prienc.sv
// Highest-set-bit encoder: picks the next register of the burst.
// R7 has priority, so the walk runs from R7 down to R0.
module lmsm_prienc
  import lmsm_pkg::*;
(
  input  logic [lmsm_pkg::NREG-1:0] i_mask,
  output logic [REG_IDX_W-1:0]      o_idx,
  output logic                      o_valid
);

  // Later (higher) set bits overwrite lower ones.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < lmsm_pkg::NREG; i++) begin
      if (i_mask[i]) begin
        o_idx   = REG_IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load/Store-Multiple sequencer: walks a register mask R7..R0,
// one memory transfer per selected register at ascending addresses.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_store,
  input  logic [AW-1:0]   base_addr,
  input  logic [NREG-1:0] reg_mask,
  output logic            busy,
  output logic            done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic [2:0]      rf_addr,
  input  logic [DW-1:0]   rf_rdata,
  output logic            rf_we,
  output logic [DW-1:0]   rf_wdata,
  output logic [3:0]      xfer_count
);

  state_t          r_state;
  state_t          w_next;
  logic [NREG-1:0] r_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [AW-1:0]   r_addr;
  logic            r_op;
  logic [3:0]      r_cnt;
  logic [2:0]      w_idx;
  logic            w_valid;
  logic            w_xfer;
  logic            w_ack;
  logic            w_go;

  lmsm_prienc u_enc (
    .i_mask  (r_mask),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_xfer     = (r_state == ST_XFER);
  assign w_ack      = w_xfer & mem_ack & w_valid;
  assign w_go       = (r_state == ST_IDLE) & start;
  assign w_clr_mask = r_mask & ~(NREG'(1) << w_idx);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: empty mask skips straight to DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start)
          w_next = (reg_mask != '0) ? ST_XFER : ST_DONE;
      end
      ST_XFER: begin
        if (w_ack && (w_clr_mask == '0))
          w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Burst context: latch on start, advance on each ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_addr <= '0;
      r_op   <= OP_LM;
      r_cnt  <= '0;
    end else if (w_go) begin
      r_mask <= reg_mask;
      r_addr <= base_addr;
      r_op   <= is_store;
      r_cnt  <= '0;
    end else if (w_ack) begin
      r_mask <= w_clr_mask;
      r_addr <= r_addr + AW'(1);
      r_cnt  <= r_cnt + 4'd1;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign mem_req    = w_xfer;
  assign mem_we     = w_xfer & (r_op == OP_SM);
  assign mem_addr   = r_addr;
  assign mem_wdata  = rf_rdata;
  assign rf_addr    = w_xfer ? w_idx : 3'd0;
  assign rf_we      = w_ack & (r_op == OP_LM);
  assign rf_wdata   = mem_rdata;
  assign xfer_count = r_cnt;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Randomised bench for lmsm_sequencer with a queue-based
// transfer model plus directed scenarios with literal checks.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        busy, done, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [2:0]  rf_addr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic [3:0]  xfer_count;

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .reg_mask   (reg_mask),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .rf_addr    (rf_addr),
    .rf_rdata   (rf_rdata),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .xfer_count (xfer_count)
  );

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
  } xf_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: pending transfers, pending done pulse, count, op.
  xf_t q[$];
  bit  m_done;
  bit  m_op;
  int  m_cnt;

  // Observations per burst.
  xf_t lg[$];
  int  busy_cyc, done_cnt, rfwe_cnt, req_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare();
    bit req;
    req = (q.size() > 0);
    chk("busy", 32'(busy), 32'(req || m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("mem_req", 32'(mem_req), 32'(req));
    chk("mem_we", 32'(mem_we), 32'(req && m_op));
    chk("rf_we", 32'(rf_we), 32'(req && mem_ack && !m_op));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
    chk("mem_wdata", 32'(mem_wdata), 32'(rf_rdata));
    chk("rf_wdata", 32'(rf_wdata), 32'(mem_rdata));
    if (req) begin
      chk("rf_addr", 32'(rf_addr), 32'(q[0].r));
      chk("mem_addr", 32'(mem_addr), 32'(q[0].a));
    end
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (rf_we) rfwe_cnt++;
    if (mem_req) req_cnt++;
    if (mem_req && mem_ack) lg.push_back('{rf_addr, mem_addr});
  endtask

  task automatic model_step();
    int k;
    if (!rst_n) return;
    if (q.size() > 0) begin
      if (mem_ack) begin
        void'(q.pop_front());
        m_cnt++;
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_op  = is_store;
      m_cnt = 0;
      k     = 0;
      for (int i = 7; i >= 0; i--) begin
        if (reg_mask[i]) begin
          q.push_back('{3'(i), base_addr + 16'(k)});
          k++;
        end
      end
      if (q.size() == 0) m_done = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic bit model_busy();
    return (q.size() > 0) || m_done;
  endfunction

  // wait_n >= 0: ack after wait_n idle cycles; < 0: random ack.
  task automatic run_burst(bit op, logic [15:0] base, logic [7:0] mask,
                           int wait_n, bit restart);
    int w;
    int n;
    lg.delete();
    busy_cyc = 0; done_cnt = 0; rfwe_cnt = 0; req_cnt = 0;
    start     = 1'b1;
    is_store  = op;
    base_addr = base;
    reg_mask  = mask;
    mem_ack   = 1'b0;
    cycle();
    start = 1'b0;
    w = 0;
    n = 0;
    while (model_busy() && n < 80) begin
      if (restart && n == 1) begin
        start     = 1'b1;
        is_store  = ~op;
        base_addr = base ^ 16'h0F0F;
        reg_mask  = 8'hFF;
      end else begin
        start     = ($urandom_range(3) == 0);
        base_addr = 16'($urandom);
        reg_mask  = 8'($urandom);
        is_store  = 1'($urandom);
      end
      if (wait_n < 0) mem_ack = ($urandom_range(99) < 65);
      else            mem_ack = (w == wait_n);
      if (mem_req) w = mem_ack ? 0 : w + 1;
      rf_rdata  = 16'($urandom);
      mem_rdata = 16'($urandom);
      cycle();
      n++;
    end
    if (model_busy()) chk("burst_timeout", 32'(n), 32'(0));
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_req"}, 32'(mem_req), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_rf_we"}, 32'(rf_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_rf_addr"}, 32'(rf_addr), 0);
    chk({tag, "_xfer_count"}, 32'(xfer_count), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0;
    base_addr = '0; reg_mask = '0; mem_ack = 1'b0;
    mem_rdata = '0; rf_rdata = '0;
    q.delete(); m_done = 1'b0; m_op = 1'b0; m_cnt = 0;
    #2;
    chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // LM, three registers, zero-wait memory.
    run_burst(1'b0, 16'h0040, 8'b1000_0101, 0, 1'b0);
    chk("t1_n", 32'(lg.size()), 3);
    chk("t1_x0", {13'd0, lg[0].r, lg[0].a}, {13'd7, 16'h0040});
    chk("t1_x1", {13'd0, lg[1].r, lg[1].a}, {13'd2, 16'h0041});
    chk("t1_x2", {13'd0, lg[2].r, lg[2].a}, {13'd0, 16'h0042});
    chk("t1_cnt", 32'(xfer_count), 3);
    chk("t1_busy", 32'(busy_cyc), 4);
    chk("t1_rfwe", 32'(rfwe_cnt), 3);
    chk("t1_done", 32'(done_cnt), 1);
    cycle();

    // SM, all registers, address wrap.
    run_burst(1'b1, 16'hFFFE, 8'hFF, 0, 1'b0);
    chk("t2_n", 32'(lg.size()), 8);
    chk("t2_x1", {13'd0, lg[1].r, lg[1].a}, {13'd6, 16'hFFFF});
    chk("t2_x2", {13'd0, lg[2].r, lg[2].a}, {13'd5, 16'h0000});
    chk("t2_x7", {13'd0, lg[7].r, lg[7].a}, {13'd0, 16'h0005});
    chk("t2_rfwe", 32'(rfwe_cnt), 0);
    chk("t2_cnt", 32'(xfer_count), 8);
    cycle();

    // SM, single register, ack delayed three cycles.
    run_burst(1'b1, 16'h1234, 8'b0001_0000, 3, 1'b0);
    chk("t3_req", 32'(req_cnt), 4);
    chk("t3_x0", {13'd0, lg[0].r, lg[0].a}, {13'd4, 16'h1234});
    chk("t3_done", 32'(done_cnt), 1);
    cycle();

    // Empty mask.
    run_burst(1'b0, 16'h2222, 8'h00, 0, 1'b0);
    chk("t4_busy", 32'(busy_cyc), 1);
    chk("t4_done", 32'(done_cnt), 1);
    chk("t4_req", 32'(req_cnt), 0);
    chk("t4_cnt", 32'(xfer_count), 0);
    cycle();

    // Restart attempt mid-burst is ignored.
    run_burst(1'b0, 16'h0100, 8'b0000_0011, 0, 1'b1);
    chk("t5_n", 32'(lg.size()), 2);
    chk("t5_x1", {13'd0, lg[1].r, lg[1].a}, {13'd0, 16'h0101});
    chk("t5_cnt", 32'(xfer_count), 2);
    cycle();

    // Reset after the first of three acks.
    lg.delete(); done_cnt = 0;
    start = 1'b1; is_store = 1'b0;
    base_addr = 16'h0300; reg_mask = 8'h07;
    cycle();
    start = 1'b0; mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_zero_outputs("midrst");
    q.delete(); m_done = 1'b0; m_cnt = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("t6_nodone", 32'(done_cnt), 0);
    run_burst(1'b0, 16'h0500, 8'h06, 0, 1'b0);
    chk("t6_x0", {13'd0, lg[0].r, lg[0].a}, {13'd2, 16'h0500});
    chk("t6_cnt", 32'(xfer_count), 2);
    cycle();

    // Random bursts.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] m;
      m = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
      run_burst(1'($urandom), 16'($urandom), m, -1,
                ($urandom_range(3) == 0));
      repeat ($urandom_range(2)) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
